// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, state encoding and sizing constants for mdu_iter
package mdu_pkg;

  localparam int MDU_WIDTH     = 32;
  localparam int MDU_DIV_ITERS = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder can reach 2*divisor-1, so compare at WIDTH+1 bits.
  assign shifted  = {rem, dvd_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit for the E stage
// Define MDU_DIV_ZERO_FAST_EN to finish divide-by-zero in a single stall cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DIV_ITERS = MDU_DIV_ITERS,
  parameter int WIDTH     = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall_o,
  output logic             hilo_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  mdu_state_t         state;
  logic [WIDTH:0]     mul_a;
  logic [WIDTH:0]     mul_b;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   divisor;
  logic               q_neg;
  logic               r_neg;
  logic [CW-1:0]      cnt;

  logic               div_signed;
  logic               mul_signed;
  logic               fast_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;

  assign stall_o    = ~flush & (((state == ST_IDLE) & start) | (state == ST_MUL) | (state == ST_DIV));
  assign hilo_valid = ~flush & (state == ST_DONE);

  assign div_signed = (op == MDU_DIV);
  assign mul_signed = (op == MDU_MULT);
  assign a_mag      = (div_signed & src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag      = (div_signed & src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MDU_DIV_ZERO_FAST_EN
  assign fast_zero = (src_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Operands are already extended to 33 bits; widening again to 2*WIDTH keeps the low product bits exact.
  assign prod = {{(WIDTH-1){mul_a[WIDTH]}}, mul_a} * {{(WIDTH-1){mul_b[WIDTH]}}, mul_b};

  // The dividend register shifts left each step and collects quotient bits in its low end.
  assign quo_next = {dvd[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !op[1]) begin
            mul_a <= {mul_signed & src_a[WIDTH-1], src_a};
            mul_b <= {mul_signed & src_b[WIDTH-1], src_b};
            state <= ST_MUL;
          end else if (start && fast_zero) begin
            hi_o  <= src_a;
            lo_o  <= '1;
            state <= ST_DONE;
          end else if (start) begin
            rem     <= '0;
            dvd     <= a_mag;
            divisor <= b_mag;
            q_neg   <= div_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg   <= div_signed & src_a[WIDTH-1];
            cnt     <= '0;
            state   <= ST_DIV;
          end
        end
        ST_MUL: begin
          hi_o  <= prod[2*WIDTH-1:WIDTH];
          lo_o  <= prod[WIDTH-1:0];
          state <= ST_DONE;
        end
        ST_DIV: begin
          rem <= rem_next;
          dvd <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_ITERS - 1)) begin
            lo_o  <= q_neg ? -quo_next : quo_next;
            hi_o  <= r_neg ? -rem_next : rem_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with a plain-arithmetic reference model
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_o;
  logic        hilo_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;

  mdu_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .stall_o    (stall_o),
    .hilo_valid (hilo_valid),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // HI/LO as the architecture defines them, result packed as {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, q, r;
    longint      p;
    logic [31:0] qq, rr;
    sa = a;
    sb = b;
    case (o)
      MDU_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        qq = a / b;
        rr = a % b;
        return {rr, qq};
      end
      default: begin
        if (b == 0) begin
`ifdef MDU_DIV_ZERO_FAST_EN
          return {a, 32'hFFFF_FFFF};
`else
          // q = all ones and r = |a|, each negated when a is negative
          return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q  = sa / sb;
        r  = sa % sb;
        qq = q;
        rr = r;
        return {rr, qq};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn && hilo_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hilo_valid", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hi_result", {32'd0, hi_o}, {32'd0, e[63:32]});
        check("lo_result", {32'd0, lo_o}, {32'd0, e[31:0]});
      end
    end
  end

  // abort_kind: 0 none, 1 flush at cycle abort_at, 2 reset at cycle abort_at
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input int abort_kind);
    logic [63:0] e;
    int          stalls;
    int          exp_stalls;
    bit          done;
    e          = model(o, a, b);
    exp_stalls = o[1] ? 33 : 2;
`ifdef MDU_DIV_ZERO_FAST_EN
    if (o[1] && b == 0) exp_stalls = 1;
`endif
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (abort_kind == 0) exp_q.push_back(e);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (abort_kind != 0 && c == abort_at) begin
        if (abort_kind == 1) begin
          flush = 1'b1;
          #1;
          check("flush_stall", {63'd0, stall_o}, 64'd0);
          check("flush_valid", {63'd0, hilo_valid}, 64'd0);
          @(posedge clk);
          #1;
          flush = 1'b0;
          start = 1'b0;
          @(negedge clk);
          check("post_flush_idle", {62'd0, stall_o, hilo_valid}, 64'd0);
          check("post_flush_hilo", {hi_o, lo_o}, last_res);
        end else begin
          resetn = 1'b0;
          start  = 1'b0;
          #1;
          check("async_rst_outputs", {hi_o, lo_o}, 64'd0);
          check("async_rst_flags", {62'd0, stall_o, hilo_valid}, 64'd0);
          #2;
          resetn   = 1'b1;
          last_res = '0;
        end
        return;
      end
      if (stall_o) stalls++;
      else done = 1'b1;
    end
    check("op_completed", {63'd0, done}, 64'd1);
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    check("valid_after_stall", {63'd0, hilo_valid}, 64'd1);
    last_res = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {63'd0, stall_o}, 64'd0);
    check("reset_valid", {63'd0, hilo_valid}, 64'd0);
    check("reset_hi", {32'd0, hi_o}, 64'd0);
    check("reset_lo", {32'd0, lo_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, -1, 0);
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, -1, 0);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, -1, 0);
    run_op(MDU_DIVU,  32'd100, 32'd7, -1, 0);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    run_op(MDU_DIV,   32'd12345, 32'd77, 10, 1);
    run_op(MDU_DIVU,  32'd9, 32'd3, -1, 0);
    run_op(MDU_DIVU,  32'd5, 32'd0, -1, 0);
    run_op(MDU_DIV,   32'hFFFF_FFFB, 32'd0, -1, 0);
    run_op(MDU_DIVU,  32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 0);
    run_op(MDU_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, -1, 0);
    run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, -1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 300));
        3:       rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, -1, 0);
    end

    run_op(MDU_DIV,  32'd1000, 32'd3, 5, 2);
    run_op(MDU_MULT, 32'h1234_5678, 32'hFEDC_BA98, -1, 0);
    run_op(MDU_DIV,  32'hFFFF_FC18, 32'd7, -1, 0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
